// File: rtl/game_pkg.sv
// game_pkg: shared encodings and width helper for the paddle/ball game core
package game_pkg;
    localparam logic [1:0] ST_HELD      = 2'b00;
    localparam logic [1:0] ST_FLIGHT    = 2'b01;
    localparam logic [1:0] ST_MISS      = 2'b10;
    localparam logic [1:0] ST_GAME_OVER = 2'b11;
    localparam logic       DIR_UP       = 1'b0;
    localparam logic       DIR_DOWN     = 1'b1;
    localparam logic [1:0] DX_NONE      = 2'b00;
    localparam logic [1:0] DX_RIGHT     = 2'b01;
    localparam logic [1:0] DX_LEFT      = 2'b11;
    function automatic int cw(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/ball_step_div.sv
// ball_step_div: counts ticks while enabled and strobes once every BALL_DIV ticks
module ball_step_div
    import game_pkg::*;
#(
    parameter int BALL_DIV = 3
) (
    input  logic buttonclk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic step_o
);
    localparam int CW = cw(BALL_DIV);
    localparam logic [CW-1:0] LAST = CW'(BALL_DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign step_o = en_i && cnt_q == LAST;
    // wrap on the step tick, otherwise advance only while enabled
    always_comb cnt_d = (clr_i || step_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    // count register
    always_ff @(posedge buttonclk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/paddle_ball_engine.sv
// paddle_ball_engine: paddle, ball, lives and score state for the LED-matrix game
module paddle_ball_engine
    import game_pkg::*;
#(
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int PADDLE_W = 3,
    parameter int BALL_DIV = 3,
    parameter int LIVES    = 3,
    parameter int SCORE_W  = 8
) (
    input  logic                     buttonclk,
    input  logic                     reset,
    input  logic                     left,
    input  logic                     right,
    input  logic                     throw,
    output logic [cw(COLS)-1:0]      paddle_x,
    output logic [cw(COLS)-1:0]      ball_x,
    output logic [cw(ROWS)-1:0]      ball_y,
    output logic [1:0]               state,
    output logic [cw(LIVES+1)-1:0]   lives,
    output logic [SCORE_W-1:0]       score,
    output logic                     hit_pulse,
    output logic                     miss_pulse
);
    localparam int XW = cw(COLS);
    localparam int YW = cw(ROWS);
    localparam int LW = cw(LIVES + 1);
    localparam logic [XW-1:0] PX_RST = XW'((COLS - PADDLE_W) / 2);
    localparam logic [XW-1:0] PX_MAX = XW'(COLS - PADDLE_W);
    localparam logic [XW-1:0] HALF   = XW'(PADDLE_W / 2);
    localparam logic [XW-1:0] PW_M1  = XW'(PADDLE_W - 1);
    localparam logic [XW-1:0] X_MAX  = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(ROWS - 1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    logic [1:0]    st_q, st_d, dx_q, dx_d, ndx;
    logic [XW-1:0] px_q, px_d, bx_q, bx_d, nx;
    logic [YW-1:0] by_q, by_d;
    logic          dy_q, dy_d, hit_q, hit_d, miss_q, miss_d;
    logic [LW-1:0] lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic          step, bounce_r, bounce_l, on_paddle;
    ball_step_div #(.BALL_DIV(BALL_DIV)) u_div (
        .buttonclk(buttonclk),
        .reset(reset),
        .en_i(st_q == ST_FLIGHT || st_q == ST_MISS),
        .clr_i(st_q == ST_HELD && throw),
        .step_o(step)
    );
    assign bounce_r  = dx_q == DX_RIGHT && bx_q == X_MAX;
    assign bounce_l  = dx_q == DX_LEFT && bx_q == '0;
    assign nx        = (bounce_l || (dx_q == DX_RIGHT && !bounce_r)) ? bx_q + 1'b1 :
                       (bounce_r || (dx_q == DX_LEFT && !bounce_l)) ? bx_q - 1'b1 : bx_q;
    assign ndx       = bounce_r ? DX_LEFT : bounce_l ? DX_RIGHT : dx_q;
    assign on_paddle = bx_q >= px_q && bx_q <= px_q + PW_M1;
    assign paddle_x   = px_q;
    assign ball_x     = (st_q == ST_HELD) ? px_q + HALF : bx_q;
    assign ball_y     = by_q;
    assign state      = st_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    // next-state: paddle moves every live tick, the ball only on divider steps
    always_comb begin
        st_d = st_q; px_d = px_q; bx_d = bx_q; by_d = by_q; dx_d = dx_q; dy_d = dy_q;
        lives_d = lives_q; score_d = score_q; hit_d = 1'b0; miss_d = 1'b0;
        if (st_q != ST_GAME_OVER)
            px_d = (left && !right && px_q != '0) ? px_q - 1'b1 :
                   (right && !left && px_q < PX_MAX) ? px_q + 1'b1 : px_q;
        case (st_q)
            ST_HELD: begin
                bx_d = px_d + HALF;
                if (throw) begin
                    st_d = ST_FLIGHT; by_d = Y_ONE; dx_d = DX_NONE; dy_d = DIR_UP;
                end
            end
            ST_FLIGHT: if (step) begin
                bx_d = nx;
                dx_d = ndx;
                if (dy_q == DIR_UP) begin
                    by_d = (by_q == Y_MAX) ? by_q - 1'b1 : by_q + 1'b1;
                    dy_d = (by_q == Y_MAX) ? DIR_DOWN : DIR_UP;
                end else if (by_q > Y_ONE) begin
                    by_d = by_q - 1'b1;
                end else if (on_paddle) begin
                    by_d = YW'(2); dy_d = DIR_UP; hit_d = 1'b1;
                    score_d = (score_q != '1) ? score_q + 1'b1 : score_q;
                    dx_d = (bx_q == px_q) ? DX_LEFT : (bx_q == px_q + PW_M1) ? DX_RIGHT : ndx;
                end else begin
                    by_d = '0; st_d = ST_MISS; miss_d = 1'b1;
                end
            end
            ST_MISS: if (step) begin
                lives_d = lives_q - 1'b1;
                st_d = (lives_q == LW'(1)) ? ST_GAME_OVER : ST_HELD;
                if (lives_q != LW'(1)) begin
                    bx_d = px_d + HALF; by_d = Y_ONE; dx_d = DX_NONE; dy_d = DIR_UP;
                end
            end
            default: ;
        endcase
    end
    // state registers with synchronous reset to the parked-ball start position
    always_ff @(posedge buttonclk) begin
        if (reset) begin
            st_q <= ST_HELD; px_q <= PX_RST; bx_q <= PX_RST + HALF; by_q <= Y_ONE;
            dx_q <= DX_NONE; dy_q <= DIR_UP; lives_q <= LW'(LIVES); score_q <= '0;
            hit_q <= 1'b0; miss_q <= 1'b0;
        end else begin
            st_q <= st_d; px_q <= px_d; bx_q <= bx_d; by_q <= by_d;
            dx_q <= dx_d; dy_q <= dy_d; lives_q <= lives_d; score_q <= score_d;
            hit_q <= hit_d; miss_q <= miss_d;
        end
    end
endmodule

// File: tb/tb_paddle_ball_engine.sv
// tb_paddle_ball_engine: scoreboard bench for the paddle/ball game core
module tb_paddle_ball_engine;
    localparam int C = 8, R = 8, PW = 3, DIV = 3, LV = 3;
    logic clk = 0, rst = 0, l = 0, r = 0, t = 0;
    logic [2:0] px, bx, by;
    logic [1:0] st, lv;
    logic [7:0] sc;
    logic hp, mp;
    logic rst2 = 0, t2 = 0;
    logic [3:0] px2, bx2;
    logic [2:0] by2;
    logic [1:0] st2, lv2;
    logic [7:0] sc2;
    logic hp2, mp2;
    int n_chk = 0, n_fail = 0;
    typedef struct { int px, bx, by, st, lv, sc, hp, mp; } exp_t;
    exp_t sb[$];
    int m_px, m_bx, m_by, m_dx, m_dy, m_st, m_lv, m_sc, m_hit, m_miss, m_div;
    bit aw_left;

    paddle_ball_engine dut (
        .buttonclk(clk), .reset(rst), .left(l), .right(r), .throw(t),
        .paddle_x(px), .ball_x(bx), .ball_y(by), .state(st), .lives(lv),
        .score(sc), .hit_pulse(hp), .miss_pulse(mp)
    );
    paddle_ball_engine #(.COLS(16), .PADDLE_W(5), .BALL_DIV(1)) dut2 (
        .buttonclk(clk), .reset(rst2), .left(1'b0), .right(1'b0), .throw(t2),
        .paddle_x(px2), .ball_x(bx2), .ball_y(by2), .state(st2), .lives(lv2),
        .score(sc2), .hit_pulse(hp2), .miss_pulse(mp2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_px = (C - PW) / 2; m_bx = m_px + PW / 2; m_by = 1; m_dx = 0; m_dy = 1;
        m_st = 0; m_lv = LV; m_sc = 0; m_hit = 0; m_miss = 0; m_div = 0;
    endtask

    task automatic model_step(input bit lf, input bit rt, input bit th);
        int npx, nbx, nby, ndx, ndy, nst, nlv, nsc;
        bit stp;
        npx = m_px; nbx = m_bx; nby = m_by; ndx = m_dx; ndy = m_dy;
        nst = m_st; nlv = m_lv; nsc = m_sc;
        m_hit = 0; m_miss = 0;
        stp = (m_st == 1 || m_st == 2) && m_div == DIV - 1;
        if (m_st == 1 || m_st == 2) m_div = stp ? 0 : m_div + 1;
        if (m_st == 0 && th) m_div = 0;
        if (m_st != 3) begin
            if (lf && !rt && m_px > 0) npx = m_px - 1;
            else if (rt && !lf && m_px < C - PW) npx = m_px + 1;
        end
        if (m_st == 0) begin
            nbx = npx + PW / 2;
            if (th) begin nst = 1; ndx = 0; ndy = 1; nby = 1; end
        end else if (m_st == 1 && stp) begin
            if (m_dx == 1 && m_bx == C - 1) begin ndx = -1; nbx = m_bx - 1; end
            else if (m_dx == -1 && m_bx == 0) begin ndx = 1; nbx = 1; end
            else nbx = m_bx + m_dx;
            if (m_dy == 1) begin
                if (m_by < R - 1) nby = m_by + 1;
                else begin ndy = 0; nby = m_by - 1; end
            end else if (m_by > 1) nby = m_by - 1;
            else if (m_bx >= m_px && m_bx <= m_px + PW - 1) begin
                ndy = 1; nby = 2; m_hit = 1;
                if (nsc < 255) nsc = nsc + 1;
                if (m_bx == m_px) ndx = -1;
                else if (m_bx == m_px + PW - 1) ndx = 1;
            end else begin
                nby = 0; nst = 2; m_miss = 1;
            end
        end else if (m_st == 2 && stp) begin
            nlv = m_lv - 1;
            if (nlv == 0) nst = 3;
            else begin nst = 0; nby = 1; ndx = 0; ndy = 1; nbx = npx + PW / 2; end
        end
        m_px = npx; m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy;
        m_st = nst; m_lv = nlv; m_sc = nsc;
    endtask

    task automatic tick(input logic rs, input logic lf, input logic rt, input logic th);
        exp_t e;
        rst = rs; l = lf; r = rt; t = th;
        if (rs) model_reset(); else model_step(lf, rt, th);
        sb.push_back('{m_px, (m_st == 0) ? m_px + PW / 2 : m_bx, m_by, m_st, m_lv, m_sc, m_hit, m_miss});
        @(posedge clk); #1;
        e = sb.pop_front();
        check("sb_paddle_x", px, e.px);
        check("sb_ball_x", bx, e.bx);
        check("sb_ball_y", by, e.by);
        check("sb_state", st, e.st);
        check("sb_lives", lv, e.lv);
        check("sb_score", sc, e.sc);
        check("sb_hit_pulse", hp, e.hp);
        check("sb_miss_pulse", mp, e.mp);
    endtask

    task automatic tick2(input logic rs, input logic th);
        rst2 = rs; t2 = th;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_paddle_x"}, px, 2);
        check({tag, "_ball_x"}, bx, 3);
        check({tag, "_ball_y"}, by, 1);
        check({tag, "_state"}, st, 0);
        check({tag, "_lives"}, lv, 3);
        check({tag, "_score"}, sc, 0);
        check({tag, "_pulses"}, {hp, mp}, 0);
    endtask

    initial begin
        tick(1, 0, 0, 0);
        check_reset_vals("reset");
        repeat (2) tick(0, 0, 1, 0);
        check("right2_paddle_x", px, 4);
        check("right2_ball_x", bx, 5);
        tick(0, 1, 1, 0);
        check("both_hold", px, 4);
        repeat (2) tick(0, 1, 0, 0);
        check("left2_paddle_x", px, 2);
        tick(0, 0, 0, 1);
        check("throw_state", st, 1);
        repeat (18) tick(0, 0, 0, 0);
        check("apex_y", by, 7);
        repeat (18) tick(0, 0, 0, 0);
        check("descend_y", by, 1);
        repeat (3) tick(0, 0, 0, 0);
        check("hit1_y", by, 2);
        check("hit1_pulse", hp, 1);
        check("hit1_score", sc, 1);
        tick(0, 0, 0, 0);
        check("hit1_pulse_drop", hp, 0);
        tick(0, 0, 1, 0);
        check("edge_paddle_x", px, 3);
        for (int i = 0; i < 60 && !hp; i++) tick(0, 0, 0, 0);
        check("hit2_pulse", hp, 1);
        check("hit2_ball_x", bx, 3);
        check("hit2_score", sc, 2);
        for (int i = 0; i < 40 && bx != 0; i++) tick(0, 0, 0, 0);
        check("edge_reach_x0", bx, 0);
        for (int i = 0; i < 5 && bx == 0; i++) tick(0, 0, 0, 0);
        check("edge_bounce_x1", bx, 1);
        for (int i = 0; i < 80 && !mp; i++) tick(0, 1, 0, 0);
        check("miss_pulse", mp, 1);
        check("miss_state", st, 2);
        check("miss_y", by, 0);
        for (int i = 0; i < 5 && st == 2; i++) tick(0, 1, 0, 0);
        check("miss_lives", lv, 2);
        check("miss_state_held", st, 0);
        check("miss_repark_x", bx, 1);
        check("miss_repark_y", by, 1);
        for (int i = 0; i < 3000 && st != 3; i++) begin
            if (st == 0) tick(0, 0, 0, 1);
            else begin
                aw_left = bx >= 4;
                tick(0, aw_left, !aw_left, 0);
            end
        end
        check("gameover_state", st, 3);
        check("gameover_lives", lv, 0);
        repeat (50) tick(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("gameover_frozen_state", st, 3);
        check("gameover_frozen_px", px, m_px);
        tick(1, 0, 0, 0);
        check_reset_vals("gameover_reset");
        tick(0, 0, 0, 1);
        for (int i = 0; i < 30 && by != 5; i++) tick(0, 0, 0, 0);
        check("midflight_y5", by, 5);
        tick(1, 0, 0, 0);
        check_reset_vals("midflight_reset");
        tick(0, 0, 0, 1);
        repeat (2) tick(0, 0, 0, 0);
        check("div_cleared_hold", by, 1);
        tick(0, 0, 0, 0);
        check("div_cleared_step", by, 2);
        tick2(1, 0);
        check("cfg2_reset_px", px2, 5);
        check("cfg2_reset_bx", bx2, 7);
        check("cfg2_reset_by", by2, 1);
        check("cfg2_reset_state", st2, 0);
        check("cfg2_reset_lives", lv2, 3);
        tick2(0, 1);
        check("cfg2_throw_state", st2, 1);
        tick2(0, 0);
        check("cfg2_step1_y", by2, 2);
        repeat (3) tick2(0, 0);
        check("cfg2_step4_y", by2, 5);
        tick2(1, 0);
        check("cfg2_mid_reset_y", by2, 1);
        check("cfg2_mid_reset_state", st2, 0);
        check("cfg2_mid_reset_px", px2, 5);
        tick2(0, 1);
        tick2(0, 0);
        check("cfg2_div_cleared", by2, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
